lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit controller that initiates data-memory transactions on behalf of the core: accepts one load or store per transaction from the execute stage, checks alignment, drives a registered valid/ready request to a byte-addressed, big-endian data memory, and returns a sign- or zero-extended load result (or store completion) to writeback. The unit holds the pipeline while a transaction is in flight and bounds every memory wait with a timeout counter.

## Interface
- TIMEOUT, 255: maximum cycles spent in REQ plus WAIT_RD before the transaction aborts with an error.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  execute stage presents a transaction.
- req_ready  out  1  unit can accept a transaction; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_mode  in  3  001 word, 010 half signed, 011 byte signed, 100 half unsigned, 101 byte unsigned; other values illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_rd  in  5  destination register for loads.
- mem_valid  out  1  request valid toward memory.
- mem_ready  in  1  memory accepts the request.
- mem_we  out  1  write request.
- mem_addr  out  32  word address: {req_addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-aligned store data.
- mem_be  out  4  byte enables; bit 3 = bits [31:24] = byte offset 0.
- mem_rdata  in  32  read word.
- mem_rvalid  in  1  mem_rdata valid.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  32  extended load data; 0 for stores and errors.
- resp_rd  out  5  req_rd of the completed transaction; 0 for stores.
- resp_err  out  1  qualifies resp_valid: misaligned, illegal mode, or timeout.
- stall  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, REQ, WAIT_RD, RESP.
- IDLE: on req_valid (req_ready=1) latch we, mode, addr, wdata, rd. Misaligned (word with addr[1:0]!=0, half with addr[0]!=0) or illegal mode -> RESP with err=1; no memory request is issued. Otherwise -> REQ.
- REQ: mem_valid=1, mem_we/addr/wdata/be held stable until mem_ready is sampled high. Stores -> RESP; loads -> WAIT_RD.
- WAIT_RD: on mem_rvalid, extract lane and extend, register into resp_data -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE.
- Big-endian lanes: byte offset k occupies bits [31-8k -: 8], mem_be[3-k]. Word: be=1111. Half at offset 0: bits [31:16], be=1100; at offset 2: bits [15:0], be=0011. Byte at offset k: one-hot be.
- Load extension: signed modes replicate the lane MSB; unsigned modes zero-fill.
- Timeout: a counter clears on IDLE->REQ and increments every cycle in REQ or WAIT_RD; on reaching TIMEOUT, -> RESP with err=1, mem_valid dropped.
- mem_ready outside REQ and mem_rvalid outside WAIT_RD are ignored.
- req_valid while not IDLE is ignored (req_ready=0); upstream holds the request.

## Timing
- Reset (rst_n low at an edge): state IDLE; req_ready=1; mem_valid, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_data, resp_rd, resp_err, stall all 0; timeout counter 0. Reset mid-transaction abandons it; no response is issued.
- All outputs are registered or decoded from state only; no combinational input-to-output path.
- Accept at edge N: mem_valid high N+1. Store with mem_ready at N+1: resp_valid in cycle N+2. Load with mem_ready at N+1 and mem_rvalid at N+2: resp_valid in cycle N+3.
- Error without memory access: resp_valid in cycle N+1.
- Back-to-back throughput: the next accept occurs no earlier than the cycle after RESP.

## Structure
- Package lsu_pkg: mode encodings as an enum, FSM state enum, lane/byte-enable constants, TIMEOUT default.
- Sub-module lsu_lane_align (combinational): store data/byte-enable alignment and load lane extraction/extension; the FSM and counter live in lsu_ctrl.

## Test plan
- Store word 0xDEADBEEF at 0x100, mem_ready immediate -> mem_addr=0x100, mem_be=1111, mem_wdata=0xDEADBEEF; resp_valid two cycles after accept, err=0.
- Store byte 0xA5 at 0x103 -> mem_be=0001, mem_wdata[7:0]=0xA5; store half 0x1234 at 0x102 -> mem_be=0011, mem_wdata[15:0]=0x1234.
- Load byte signed at 0x201, mem_rdata=0x0080FF00 -> resp_data=0xFFFFFF80; same with unsigned mode -> 0x00000080; resp_rd echoes req_rd.
- Load word at 0x102 -> no mem_valid, resp_valid one cycle after accept with err=1; mode 110 -> same.
- mem_ready held low for TIMEOUT cycles -> mem_valid drops, resp_valid with err=1; a load with 3-cycle mem_rvalid delay -> stall high throughout, req_ready low.
- Assert rst_n low during WAIT_RD -> all outputs 0 next cycle; a late mem_rvalid afterwards produces no resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit controller.
//   lsu_mode_e  - request size/extension encodings (req_mode)
//   lsu_state_e - controller FSM states
//   BE_*        - big-endian byte-enable patterns (bit 3 = byte offset 0)
//   TIMEOUT_DEF - default bound on REQ+WAIT_RD cycles
//   lsu_req_bad - flags misaligned or illegal-mode requests
package lsu_pkg;

    typedef enum logic [2:0] {
        MODE_WORD   = 3'b001,
        MODE_HALF_S = 3'b010,
        MODE_BYTE_S = 3'b011,
        MODE_HALF_U = 3'b100,
        MODE_BYTE_U = 3'b101
    } lsu_mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RD,
        S_RESP
    } lsu_state_e;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_HALF0 = 4'b1100;
    localparam logic [3:0] BE_BYTE0 = 4'b1000;

    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned CNT_W       = 8;

    function automatic logic lsu_req_bad(input logic [2:0] mode, input logic [1:0] off);
        case (mode)
            MODE_WORD:                return off != 2'b00;
            MODE_HALF_S, MODE_HALF_U: return off[0];
            MODE_BYTE_S, MODE_BYTE_U: return 1'b0;
            default:                  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational big-endian lane steering.
//   mode      in  3   request mode (lsu_mode_e encoding)
//   offset    in  2   byte offset within the word
//   wdata     in  32  right-justified store data
//   rdata     in  32  read word from memory
//   wdata_al  out 32  store data placed in its lane(s)
//   be        out 4   byte enables (0 for illegal modes)
//   rdata_ext out 32  extracted and sign/zero-extended load data
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_al,
    output logic [3:0]  be,
    output logic [31:0] rdata_ext
);

    // Byte offset k lives at bits [31-8k -: 8]; halves at offset 0 or 2.
    logic [4:0] sh_b;
    logic [4:0] sh_h;
    logic [4:0] top_b;
    logic [4:0] top_h;
    logic [7:0] lane_b;
    logic [15:0] lane_h;
    logic       sgn;

    always_comb begin
        sh_b   = {~offset, 3'b000};
        sh_h   = offset[1] ? 5'd0 : 5'd16;
        top_b  = {~offset, 3'b111};
        top_h  = offset[1] ? 5'd15 : 5'd31;
        lane_b = rdata[top_b -: 8];
        lane_h = rdata[top_h -: 16];
        sgn    = (mode == MODE_HALF_S) || (mode == MODE_BYTE_S);

        wdata_al  = '0;
        be        = '0;
        rdata_ext = '0;
        case (mode)
            MODE_WORD: begin
                wdata_al  = wdata;
                be        = BE_WORD;
                rdata_ext = rdata;
            end
            MODE_HALF_S, MODE_HALF_U: begin
                wdata_al  = {16'b0, wdata[15:0]} << sh_h;
                be        = BE_HALF0 >> {offset[1], 1'b0};
                rdata_ext = {{16{sgn & lane_h[15]}}, lane_h};
            end
            MODE_BYTE_S, MODE_BYTE_U: begin
                wdata_al  = {24'b0, wdata[7:0]} << sh_b;
                be        = BE_BYTE0 >> offset;
                rdata_ext = {{24{sgn & lane_b[7]}}, lane_b};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller.
// Accepts one load/store from execute (req_*), checks alignment, issues a
// valid/ready request to a big-endian byte-addressed memory (mem_*), and
// returns extended load data or store completion as a one-cycle pulse (resp_*).
// stall is high whenever a transaction is in flight. REQ+WAIT_RD time is
// bounded by TIMEOUT cycles, after which the transaction ends with resp_err.
// All outputs come from flops or decode of state/latched request only.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        stall
);

    lsu_state_e       state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       mode_q, mode_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [4:0]       rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic [4:0]       resp_rd_q, resp_rd_d;
    logic             resp_err_q, resp_err_d;

    logic [31:0] wdata_al;
    logic [3:0]  be_al;
    logic [31:0] rdata_ext;
    logic        timed_out;

    // Steering runs off the latched request so memory-side outputs never
    // depend combinationally on req_* inputs; a reset latch decodes to zero.
    lsu_lane_align u_align (
        .mode      (mode_q),
        .offset    (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .wdata_al  (wdata_al),
        .be        (be_al),
        .rdata_ext (rdata_ext)
    );

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_rd_d   = resp_rd_q;
        resp_err_d  = resp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    mode_d  = req_mode;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    if (lsu_req_bad(req_mode, req_addr[1:0])) begin
                        state_d     = S_RESP;
                        resp_err_d  = 1'b1;
                        resp_data_d = '0;
                        resp_rd_d   = req_we ? 5'd0 : req_rd;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_ready) begin
                    if (we_q) begin
                        state_d     = S_RESP;
                        resp_err_d  = 1'b0;
                        resp_data_d = '0;
                        resp_rd_d   = '0;
                    end else begin
                        state_d = S_WAIT_RD;
                    end
                end else if (timed_out) begin
                    state_d     = S_RESP;
                    resp_err_d  = 1'b1;
                    resp_data_d = '0;
                    resp_rd_d   = we_q ? 5'd0 : rd_q;
                end
            end
            S_WAIT_RD: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    state_d     = S_RESP;
                    resp_err_d  = 1'b0;
                    resp_data_d = rdata_ext;
                    resp_rd_d   = rd_q;
                end else if (timed_out) begin
                    state_d     = S_RESP;
                    resp_err_d  = 1'b1;
                    resp_data_d = '0;
                    resp_rd_d   = rd_q;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            mode_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_rd_q   <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_rd_q   <= resp_rd_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign stall      = (state_q != S_IDLE);
    assign mem_valid  = (state_q == S_REQ);
    assign resp_valid = (state_q == S_RESP);
    assign mem_we     = we_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = wdata_al;
    assign mem_be     = be_al;
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        stall;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    lsu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_mode   (req_mode),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        req_valid = 1'b1; req_we = 1'b1; req_mode = mode; req_addr = addr;
        req_wdata = wd; req_rd = 5'd9; mem_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check_eq("st_mem_valid", mem_valid, 1);
        check_eq("st_mem_we", mem_we, 1);
        check_eq("st_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check_eq("st_mem_be", mem_be, exp_be);
        check_eq("st_mem_wdata", mem_wdata, exp_wd);
        check_eq("st_resp_early", resp_valid, 0);
        tick();
        mem_ready = 1'b0;
        check_eq("st_resp_valid", resp_valid, 1);
        check_eq("st_resp_err", resp_err, 0);
        check_eq("st_resp_rd", resp_rd, 0);
        check_eq("st_resp_data", resp_data, 0);
        tick();
        check_eq("st_resp_done", resp_valid, 0);
        check_eq("st_ready_back", req_ready, 1);
    endtask

    task automatic do_load(input logic [2:0] mode, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] rdata, input int unsigned delay,
                           input logic [31:0] exp_data);
        req_valid = 1'b1; req_we = 1'b0; req_mode = mode; req_addr = addr;
        req_wdata = 32'h5555_5555; req_rd = rd; mem_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check_eq("ld_mem_valid", mem_valid, 1);
        check_eq("ld_mem_we", mem_we, 0);
        check_eq("ld_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        tick();
        mem_ready = 1'b0;
        for (int unsigned i = 0; i < delay; i++) begin
            check_eq("ld_wait_stall", stall, 1);
            check_eq("ld_wait_ready", req_ready, 0);
            check_eq("ld_wait_mvalid", mem_valid, 0);
            check_eq("ld_wait_resp", resp_valid, 0);
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        check_eq("ld_resp_valid", resp_valid, 1);
        check_eq("ld_resp_err", resp_err, 0);
        check_eq("ld_resp_data", resp_data, exp_data);
        check_eq("ld_resp_rd", resp_rd, rd);
        tick();
        check_eq("ld_resp_done", resp_valid, 0);
    endtask

    task automatic do_bad(input logic we, input logic [2:0] mode, input logic [31:0] addr);
        req_valid = 1'b1; req_we = we; req_mode = mode; req_addr = addr;
        req_wdata = 32'h1111_2222; req_rd = 5'd4; mem_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check_eq("err_no_mvalid", mem_valid, 0);
        check_eq("err_resp_valid", resp_valid, 1);
        check_eq("err_resp_err", resp_err, 1);
        check_eq("err_resp_data", resp_data, 0);
        tick();
        mem_ready = 1'b0;
        check_eq("err_resp_done", resp_valid, 0);
        check_eq("err_no_mvalid2", mem_valid, 0);
        check_eq("err_ready_back", req_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_mode = 3'b000;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
        tick();
        tick();
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_mem_valid", mem_valid, 0);
        check_eq("rst_mem_be", mem_be, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_data", resp_data, 0);
        rst_n = 1'b1;
        tick();

        // Stores: word, bytes, halves (upper junk in wdata must not leak)
        do_store(3'b001, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        do_store(3'b011, 32'h0000_0103, 32'hFFFF_FFA5, 4'b0001, 32'h0000_00A5);
        do_store(3'b101, 32'h0000_0100, 32'h0000_00A5, 4'b1000, 32'hA500_0000);
        do_store(3'b011, 32'h0000_0101, 32'h0000_003C, 4'b0100, 32'h003C_0000);
        do_store(3'b010, 32'h0000_0102, 32'hABCD_1234, 4'b0011, 32'h0000_1234);
        do_store(3'b100, 32'h0000_0100, 32'hABCD_1234, 4'b1100, 32'h1234_0000);

        // Loads
        do_load(3'b011, 32'h0000_0201, 5'd17, 32'h0080_FF00, 0, 32'hFFFF_FF80);
        do_load(3'b101, 32'h0000_0201, 5'd18, 32'h0080_FF00, 0, 32'h0000_0080);
        do_load(3'b011, 32'h0000_0202, 5'd3,  32'h0080_FF00, 0, 32'hFFFF_FFFF);
        do_load(3'b101, 32'h0000_0203, 5'd5,  32'h0080_FF7E, 1, 32'h0000_007E);
        do_load(3'b010, 32'h0000_0200, 5'd6,  32'h8001_7FFF, 0, 32'hFFFF_8001);
        do_load(3'b010, 32'h0000_0202, 5'd7,  32'h8001_7FFF, 0, 32'h0000_7FFF);
        do_load(3'b100, 32'h0000_0202, 5'd8,  32'h1234_F00F, 0, 32'h0000_F00F);
        do_load(3'b001, 32'h0000_0204, 5'd31, 32'hCAFE_F00D, 3, 32'hCAFE_F00D);

        // Misaligned / illegal mode
        do_bad(1'b0, 3'b001, 32'h0000_0102);
        do_bad(1'b0, 3'b110, 32'h0000_0100);
        do_bad(1'b1, 3'b010, 32'h0000_0201);
        do_bad(1'b0, 3'b000, 32'h0000_0100);

        // Timeout: mem_ready never asserted
        req_valid = 1'b1; req_we = 1'b1; req_mode = 3'b001; req_addr = 32'h0000_0300;
        req_wdata = 32'h0BAD_F00D; req_rd = 5'd0; mem_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        check_eq("to_mvalid_first", mem_valid, 1);
        for (int unsigned i = 0; i < 254; i++) tick();
        check_eq("to_mvalid_last", mem_valid, 1);
        check_eq("to_resp_early", resp_valid, 0);
        tick();
        check_eq("to_mvalid_drop", mem_valid, 0);
        check_eq("to_resp_valid", resp_valid, 1);
        check_eq("to_resp_err", resp_err, 1);
        tick();
        check_eq("to_idle", req_ready, 1);

        // Reset during WAIT_RD abandons the load
        req_valid = 1'b1; req_we = 1'b0; req_mode = 3'b001; req_addr = 32'h0000_0400;
        req_rd = 5'd12; mem_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        mem_ready = 1'b0;
        check_eq("rw_stall", stall, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("rw_stall0", stall, 0);
        check_eq("rw_mvalid0", mem_valid, 0);
        check_eq("rw_maddr0", mem_addr, 0);
        check_eq("rw_mbe0", mem_be, 0);
        check_eq("rw_mwdata0", mem_wdata, 0);
        check_eq("rw_resp_data0", resp_data, 0);
        check_eq("rw_ready", req_ready, 1);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        check_eq("rw_no_resp1", resp_valid, 0);
        tick();
        check_eq("rw_no_resp2", resp_valid, 0);
        check_eq("rw_idle", stall, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
